daisy_cp_lock_ctrl: RTL and testbench
=====================================

// Module: daisy_cp_lock_ctrl
// PURPOSE
//  Digital sequencer/lock monitor for the charge-pump integrator of the daisy PLL.
//  Clears the integrator, enables the pump, and measures UP/DWN pulse widths per reference period.
//  Declares lock or timeout-failure from these measurements, and drops lock on excessive phase error.
//  Sits between the PFD (up/dwn) and the charge-pump integrator (cp_en/cp_rst).
// PARAMETERS
//  CNT_W      8    width of UP/DWN high-time counters (clk cycles per ref period)
//  LOCK_TOL   2    |phase_err| <= LOCK_TOL counts as a good period
//  LOCK_CNT   16   consecutive good periods needed to declare lock (>=1)
//  UNLOCK_TOL 6    |phase_err| > UNLOCK_TOL in LOCK drops lock (UNLOCK_TOL >= LOCK_TOL)
//  TIMEOUT    1023 ref periods allowed in ACQ before FAIL (10-bit period counter)
//  RST_CYC    4    clk cycles cp_rst is held in CLR (>=1)
// PORTS
//  clk        in   1        system clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  start      in   1        level/pulse: begin acquisition from IDLE or FAIL
//  stop       in   1        pulse: abort to IDLE from any state
//  ref_tick   in   1        one-cycle pulse marking each reference-period boundary
//  up         in   1        PFD UP, asynchronous to clk
//  dwn        in   1        PFD DWN, asynchronous to clk
//  cp_en      out  1        charge-pump enable
//  cp_rst     out  1        charge-pump integrator clear
//  locked     out  1        lock indicator
//  fail       out  1        acquisition timeout indicator
//  phase_err  out  CNT_W+1  signed up_cnt-dwn_cnt of last completed period
//  state      out  3        FSM state: IDLE=0 CLR=1 ACQ=2 LOCK=3 FAIL=4
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, counters/synchronisers cleared.
//  up/dwn: each passes through a 2-flop synchroniser (2-cycle latency), then feeds its counter.
//  up_cnt/dwn_cnt: +1 per cycle the synced signal is high. Saturate at 2^CNT_W-1; no wrap.
//  Counters are held at 0 in IDLE and CLR.
//  ref_tick (ACQ/LOCK/FAIL only): phase_err <= up_cnt-dwn_cnt, sign-extended to CNT_W+1, registered.
//   On the same edge, counters restart. The tick cycle's synced level counts into the new period.
//   Ticks in IDLE/CLR are ignored; phase_err holds its value.
//  Lock decisions use the error computed at the tick, i.e. the same edge that updates phase_err.
//  FSM (stop has highest priority: any state -> IDLE next edge, even with start/tick):
//   IDLE: cp_en=0 cp_rst=0. start -> CLR.
//   CLR:  cp_rst=1, cp_en=0 for exactly RST_CYC cycles -> ACQ. Clears good_cnt and period_cnt.
//   ACQ:  cp_en=1. Each tick: period_cnt++; good_cnt = good ? good_cnt+1 : 0.
//         good_cnt==LOCK_CNT -> LOCK, which has priority over timeout on the same tick.
//         Otherwise period_cnt==TIMEOUT -> FAIL.
//   LOCK: cp_en=1 locked=1. Tick with |err|>UNLOCK_TOL -> ACQ; good_cnt=0, period_cnt=0.
//         Errors between LOCK_TOL and UNLOCK_TOL keep lock (hysteresis).
//   FAIL: cp_en=0 fail=1, held until start -> CLR or stop -> IDLE.
//  Outputs are registered and decoded from the state register. locked/fail drop on the edge leaving the state.
//  start while in CLR/ACQ/LOCK is ignored.
//  rst_n low mid-operation forces reset values immediately (async), including cp_en=0.
// TESTING
//  T1 reset: rst_n=0 mid-LOCK -> cp_en=locked=0, state=0 without a clk edge; phase_err=0.
//  T2 clr: start pulse in IDLE -> cp_rst=1 exactly 4 cycles; then state=2, cp_en=1.
//  T3 lock: ticks every 50 clk, up high 10, dwn high 9 -> phase_err=+1.
//   Expect locked=1 on the 16th tick after entering ACQ.
//  T4 unlock: in LOCK, up=20, dwn=14 (err=+6) -> stays locked.
//   Then up=20, dwn=13 (err=+7) -> state=2, locked=0.
//  T5 timeout: err alternates +3/0 forever -> fail=1 and cp_en=0 on the 1023rd tick.
//   Then start -> CLR.
//  T6 corners: up held high 300 clk, CNT_W=8 -> phase_err=+255 (saturated).
//   stop+start on the same edge in FAIL -> IDLE.

Source files
------------

// File: rtl/daisy_cp_lock_ctrl.sv
// Charge-pump sequencer and lock monitor for the daisy PLL: clears/enables the
// integrator and judges lock from synchronised UP/DWN high time per reference period.
module daisy_cp_lock_ctrl #(
  parameter int CNT_W      = 8,
  parameter int LOCK_TOL   = 2,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_TOL = 6,
  parameter int TIMEOUT    = 1023,
  parameter int RST_CYC    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           stop,
  input  logic           ref_tick,
  input  logic           up,
  input  logic           dwn,
  output logic           cp_en,
  output logic           cp_rst,
  output logic           locked,
  output logic           fail,
  output logic [CNT_W:0] phase_err,
  output logic [2:0]     state
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int PW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYC + 1);
  localparam logic [GW-1:0]  LOCK_CNT_V   = GW'(LOCK_CNT);
  localparam logic [PW-1:0]  TIMEOUT_V    = PW'(TIMEOUT);
  localparam logic [RW-1:0]  RST_LAST_V   = RW'(RST_CYC - 1);
  localparam logic [CNT_W:0] LOCK_TOL_V   = (CNT_W + 1)'(LOCK_TOL);
  localparam logic [CNT_W:0] UNLOCK_TOL_V = (CNT_W + 1)'(UNLOCK_TOL);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_ACQ  = 3'd2,
    S_LOCK = 3'd3,
    S_FAIL = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [GW-1:0]      good_reg, good_inc;
  logic [PW-1:0]      period_reg, period_inc;
  logic [RW-1:0]      clr_reg;
  logic               cp_en_reg, cp_rst_reg, locked_reg, fail_reg;
  logic [CNT_W:0]     phase_err_reg, err_now, err_abs;
  logic [1:0]         pfd_in;
  logic [2*CNT_W-1:0] cnt_flat;
  logic [CNT_W-1:0]   up_cnt, dwn_cnt;
  logic               active;

  assign pfd_in  = {dwn, up};
  assign active  = (state_reg == S_ACQ) || (state_reg == S_LOCK) || (state_reg == S_FAIL);
  assign up_cnt  = cnt_flat[CNT_W-1:0];
  assign dwn_cnt = cnt_flat[2*CNT_W-1:CNT_W];

  // Channel 0 = UP, channel 1 = DWN: 2-flop synchroniser feeding a saturating
  // high-time counter that restarts on each tick with the tick cycle's level.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic             s1_reg, s2_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg  <= 1'b0;
          s2_reg  <= 1'b0;
          cnt_reg <= '0;
        end else begin
          s1_reg <= pfd_in[gi];
          s2_reg <= s1_reg;
          if (!active)
            cnt_reg <= '0;
          else if (ref_tick)
            cnt_reg <= CNT_W'(s2_reg);
          else if (s2_reg && (cnt_reg != '1))
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate

  assign err_now    = {1'b0, up_cnt} - {1'b0, dwn_cnt};
  assign err_abs    = err_now[CNT_W] ? (~err_now + (CNT_W + 1)'(1)) : err_now;
  assign good_inc   = (err_abs <= LOCK_TOL_V) ? (good_reg + GW'(1)) : '0;
  assign period_inc = period_reg + PW'(1);

  always_comb begin
    state_next = state_reg;
    if (stop) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: if (start) state_next = S_CLR;
        S_CLR:  if (clr_reg == RST_LAST_V) state_next = S_ACQ;
        S_ACQ: begin
          // Lock wins over timeout when both land on the same tick.
          if (ref_tick) begin
            if (good_inc == LOCK_CNT_V)
              state_next = S_LOCK;
            else if (period_inc == TIMEOUT_V)
              state_next = S_FAIL;
          end
        end
        S_LOCK: if (ref_tick && (err_abs > UNLOCK_TOL_V)) state_next = S_ACQ;
        S_FAIL: if (start) state_next = S_CLR;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the destination state so they change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      clr_reg       <= '0;
      good_reg      <= '0;
      period_reg    <= '0;
      phase_err_reg <= '0;
      cp_en_reg     <= 1'b0;
      cp_rst_reg    <= 1'b0;
      locked_reg    <= 1'b0;
      fail_reg      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      clr_reg    <= ((state_reg == S_CLR) && (state_next == S_CLR)) ? clr_reg + RW'(1) : '0;
      cp_en_reg  <= (state_next == S_ACQ) || (state_next == S_LOCK);
      cp_rst_reg <= (state_next == S_CLR);
      locked_reg <= (state_next == S_LOCK);
      fail_reg   <= (state_next == S_FAIL);
      if (state_reg != S_ACQ) begin
        good_reg   <= '0;
        period_reg <= '0;
      end else if (ref_tick) begin
        good_reg   <= good_inc;
        period_reg <= period_inc;
      end
      if (ref_tick && active)
        phase_err_reg <= err_now;
    end
  end

  assign cp_en     = cp_en_reg;
  assign cp_rst    = cp_rst_reg;
  assign locked    = locked_reg;
  assign fail      = fail_reg;
  assign phase_err = phase_err_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_daisy_cp_lock_ctrl.sv
// Scoreboard bench for daisy_cp_lock_ctrl: a per-period reference model predicts
// phase error and state at every tick; a monitor compares after each tick edge.
module tb_daisy_cp_lock_ctrl;
  localparam int CNT_W = 8, LOCK_TOL = 2, LOCK_CNT = 16, UNLOCK_TOL = 6;
  localparam int TIMEOUT = 1023, RST_CYC = 4;
  localparam int S_IDLE = 0, S_CLR = 1, S_ACQ = 2, S_LOCK = 3, S_FAIL = 4;
  localparam int SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic ref_tick = 1'b0, up = 1'b0, dwn = 1'b0;
  logic cp_en, cp_rst, locked, fail;
  logic [CNT_W:0] phase_err;
  logic [2:0] state;

  int checks = 0, errors = 0, txn = 0;

  typedef struct {int err; int st;} exp_t;
  exp_t exp_q[$];

  // Reference model: per-period abstraction of the controller.
  int m_state = S_IDLE, m_good = 0, m_period = 0, m_err = 0;

  always #5 clk = ~clk;

  daisy_cp_lock_ctrl #(
    .CNT_W(CNT_W), .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT),
    .UNLOCK_TOL(UNLOCK_TOL), .TIMEOUT(TIMEOUT), .RST_CYC(RST_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ref_tick(ref_tick),
    .up(up), .dwn(dwn), .cp_en(cp_en), .cp_rst(cp_rst), .locked(locked),
    .fail(fail), .phase_err(phase_err), .state(state)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_state"}, int'(state), m_state);
    check({tag, "_locked"}, int'(locked), int'(m_state == S_LOCK));
    check({tag, "_fail"}, int'(fail), int'(m_state == S_FAIL));
    check({tag, "_cp_en"}, int'(cp_en), int'(m_state == S_ACQ || m_state == S_LOCK));
    check({tag, "_cp_rst"}, int'(cp_rst), int'(m_state == S_CLR));
    check({tag, "_phase_err"}, int'($signed(phase_err)), m_err);
  endtask

  // Apply the rules for one completed period with u/dwn high times u and d.
  task automatic model_tick(input int u, input int d);
    int err, mag;
    err = (u > SAT ? SAT : u) - (d > SAT ? SAT : d);
    mag = (err < 0) ? -err : err;
    if (m_state == S_ACQ || m_state == S_LOCK || m_state == S_FAIL)
      m_err = err;
    if (m_state == S_ACQ) begin
      m_period++;
      m_good = (mag <= LOCK_TOL) ? m_good + 1 : 0;
      if (m_good == LOCK_CNT) m_state = S_LOCK;
      else if (m_period == TIMEOUT) m_state = S_FAIL;
    end else if (m_state == S_LOCK && mag > UNLOCK_TOL) begin
      m_state  = S_ACQ;
      m_good   = 0;
      m_period = 0;
    end
    exp_q.push_back('{m_err, m_state});
  endtask

  // One reference period: pulses well inside the period, tick on the last cycle.
  task automatic run_period(input int u, input int d, input int len);
    int l;
    l = len;
    if (l < (u > d ? u : d) + 6) l = (u > d ? u : d) + 6;
    for (int c = 0; c < l; c++) begin
      @(negedge clk);
      up       = (c >= 1 && c <= u);
      dwn      = (c >= 1 && c <= d);
      ref_tick = (c == l - 1);
    end
    model_tick(u, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      up = 1'b0; dwn = 1'b0; ref_tick = 1'b0; start = 1'b0; stop = 1'b0;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    ref_tick = 1'b0; up = 1'b0; dwn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (m_state == S_IDLE || m_state == S_FAIL) begin
      m_state = S_CLR;
      for (int i = 0; i < RST_CYC; i++) begin
        check("clr_cp_rst", int'(cp_rst), 1);
        check("clr_state", int'(state), S_CLR);
        check("clr_cp_en", int'(cp_en), 0);
        if (i < RST_CYC - 1) @(negedge clk);
      end
      @(negedge clk);
      m_state = S_ACQ; m_good = 0; m_period = 0;
      check_model("acq_entry");
      $display("start: clear for %0d cycles, now state=%0d", RST_CYC, m_state);
    end else begin
      check_model("start_ignored");
      $display("start: ignored in state=%0d", m_state);
    end
  endtask

  task automatic do_stop(input logic with_start);
    @(negedge clk);
    ref_tick = 1'b0; up = 1'b0; dwn = 1'b0; stop = 1'b1; start = with_start;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    m_state = S_IDLE;
    check_model(with_start ? "stop_start" : "stop");
    $display("stop (start=%0d): state=%0d", with_start, int'(state));
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_state = S_IDLE; m_good = 0; m_period = 0; m_err = 0;
    check_model("async_reset");
    $display("async reset mid-cycle: state=%0d cp_en=%0d locked=%0d", int'(state), cp_en, locked);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every tick edge is a transaction; pop and compare half a cycle later.
  initial begin
    exp_t e;
    int e0;
    forever begin
      @(posedge clk);
      if (ref_tick && rst_n) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got a tick with no expectation, required a queued entry");
        end else begin
          e  = exp_q.pop_front();
          e0 = errors;
          check("tick_phase_err", int'($signed(phase_err)), e.err);
          check("tick_state", int'(state), e.st);
          check("tick_locked", int'(locked), int'(e.st == S_LOCK));
          check("tick_fail", int'(fail), int'(e.st == S_FAIL));
          check("tick_cp_en", int'(cp_en), int'(e.st == S_ACQ || e.st == S_LOCK));
          if (errors == e0)
            $display("txn %0d: tick phase_err=%0d state=%0d ok", txn, e.err, e.st);
          txn++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int u, d, len;
    #3;
    check_model("reset");
    idle(2);
    rst_n = 1'b1;
    idle(2);
    run_period(7, 2, 15);                        // tick in IDLE is ignored
    do_start();
    do_start();                                  // ignored in ACQ
    repeat (LOCK_CNT) run_period(10, 9, 50);     // lock on 16th tick
    run_period(20, 14, 40);                      // +6 keeps lock
    run_period(20, 14, 40);
    run_period(20, 13, 40);                      // +7 drops lock
    repeat (LOCK_CNT) run_period(5, 5, 20);
    idle(3);
    async_reset();
    idle(2);
    do_start();
    run_period(300, 0, 310);                     // saturates at +255
    run_period(0, 300, 310);                     // saturates at -255
    repeat (24) begin
      u = int'($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) d = u + int'($urandom_range(0, 16)) - 8;
      else d = int'($urandom_range(0, 40));
      if (d < 0) d = 0;
      len = (u > d ? u : d) + 6 + int'($urandom_range(0, 4));
      run_period(u, d, len);
    end
    do_stop(1'b0);
    do_start();
    for (int i = 0; i < TIMEOUT; i++) run_period((i % 2 == 0) ? 3 : 0, 0, 9);
    idle(1);
    check("timeout_fail", int'(fail), 1);
    check("timeout_cp_en", int'(cp_en), 0);
    run_period(4, 1, 12);                        // ticks still measured in FAIL
    do_start();                                  // FAIL -> CLR
    for (int i = 0; i < TIMEOUT; i++) run_period((i % 2 == 0) ? 3 : 0, 0, 9);
    idle(1);
    check_model("second_timeout");
    do_stop(1'b1);                               // stop beats start
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
